// File: rtl/cpu_bus_arb_pkg.sv
// Shared types and constants for the CPU memory-side bus arbiter.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0000;

  // The core encodes word as either 10 or 11.
  function automatic size_e decode_size(input logic [1:0] be);
    case (be)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_arb_if.sv
// CPU fetch/data ports plus the pipelined memory master port.
// master: arbiter view; slave: view of the CPU core and memory around it.
interface cpu_bus_arb_if;
  logic        inst_cyc_in;
  logic        inst_stb_in;
  logic [31:0] inst_addr_in;
  logic        inst_ack_out;
  logic [31:0] inst_data_out;
  logic        inst_stall_out;
  logic        data_stb_in;
  logic        data_we_in;
  logic [1:0]  data_be_in;
  logic [31:0] data_addr_in;
  logic [31:0] data_data_in;
  logic        data_ack_out;
  logic [31:0] data_data_out;
  logic        mem_cyc_out;
  logic        mem_stb_out;
  logic        mem_we_out;
  logic [3:0]  mem_sel_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
  logic        mem_stall_in;
  logic        bus_err_out;

  modport master (
    input  inst_cyc_in, inst_stb_in, inst_addr_in,
    output inst_ack_out, inst_data_out, inst_stall_out,
    input  data_stb_in, data_we_in, data_be_in, data_addr_in, data_data_in,
    output data_ack_out, data_data_out,
    output mem_cyc_out, mem_stb_out, mem_we_out, mem_sel_out, mem_addr_out, mem_data_out,
    input  mem_ack_in, mem_data_in, mem_stall_in,
    output bus_err_out
  );

  modport slave (
    output inst_cyc_in, inst_stb_in, inst_addr_in,
    input  inst_ack_out, inst_data_out, inst_stall_out,
    output data_stb_in, data_we_in, data_be_in, data_addr_in, data_data_in,
    input  data_ack_out, data_data_out,
    input  mem_cyc_out, mem_stb_out, mem_we_out, mem_sel_out, mem_addr_out, mem_data_out,
    output mem_ack_in, mem_data_in, mem_stall_in,
    input  bus_err_out
  );
endinterface

// File: rtl/cpu_bus_arb_lane_align.sv
// Byte-lane steering: write selects/replication and read right-alignment.
module bus_lane_align
  import cpu_bus_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_lo, 3'b000};

  // Lane selects and data steering for the given access size and offset.
  always_comb begin
    o_sel   = '1;
    o_wdata = i_wdata;
    o_rdata = w_shift;
    case (i_size)
      SZ_BYTE: begin
        o_sel   = 4'b0001 << i_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h0, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_sel   = 4'b0011 << {i_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0, w_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_bus_arb.sv
// Merges the CPU fetch and data ports onto one memory master port,
// one outstanding transaction, round-robin on contention, with timeout.
module cpu_bus_arb
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  cpu_bus_arb_if.master bus
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e        r_state, w_next;
  grant_e        r_owner, r_last, w_gnt;
  size_e         r_size, w_sz_req, w_sz;
  logic [1:0]    r_lo, w_lo;
  logic [29:0]   r_waddr;
  logic          r_we, r_err;
  logic [3:0]    r_sel, w_sel;
  logic [31:0]   r_wdata, r_rdata, w_wdata, w_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_inst_req, w_data_req, w_mis, w_busy, w_tmo, w_abort, w_take;
  logic          w_unused;

  assign w_unused   = ^bus.inst_addr_in[1:0];
  assign w_inst_req = bus.inst_cyc_in & bus.inst_stb_in;
  assign w_data_req = bus.data_stb_in;
  assign w_sz_req   = decode_size(bus.data_be_in);
  assign w_mis      = is_misaligned(w_sz_req, bus.data_addr_in[1:0]);
  assign w_busy     = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_tmo      = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_abort    = (r_owner == GNT_INST) && !bus.inst_cyc_in;
  assign w_take     = ((r_state == ST_REQ) && !bus.mem_stall_in && bus.mem_ack_in) ||
                      ((r_state == ST_WAIT) && bus.mem_ack_in);

  // Round-robin choice among pending requests (only meaningful in IDLE).
  always_comb begin
    w_gnt = GNT_INST;
    if (w_inst_req && w_data_req) w_gnt = (r_last == GNT_INST) ? GNT_DATA : GNT_INST;
    else if (w_data_req)          w_gnt = GNT_DATA;
  end

  // One aligner serves both directions: in IDLE it shapes the request being
  // granted, afterwards it aligns read data using the latched size/offset.
  always_comb begin
    w_sz = r_size;
    w_lo = r_lo;
    if (r_state == ST_IDLE) begin
      w_sz = (w_gnt == GNT_DATA) ? w_sz_req : SZ_WORD;
      w_lo = (w_gnt == GNT_DATA) ? bus.data_addr_in[1:0] : 2'b00;
    end
  end

  bus_lane_align u_align (
    .i_size  (w_sz),
    .i_lo    (w_lo),
    .i_wdata (bus.data_data_in),
    .i_rdata (bus.mem_data_in),
    .o_sel   (w_sel),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and all port outputs.
  always_comb begin
    w_next             = r_state;
    bus.mem_cyc_out    = w_busy;
    bus.mem_stb_out    = (r_state == ST_REQ);
    bus.mem_we_out     = w_busy & r_we;
    bus.mem_sel_out    = w_busy ? r_sel : '0;
    bus.mem_addr_out   = w_busy ? {r_waddr, 2'b00} : '0;
    bus.mem_data_out   = w_busy ? r_wdata : '0;
    bus.inst_ack_out   = (r_state == ST_RESP) && (r_owner == GNT_INST);
    bus.data_ack_out   = (r_state == ST_RESP) && (r_owner == GNT_DATA);
    bus.inst_data_out  = bus.inst_ack_out ? r_rdata : '0;
    bus.data_data_out  = bus.data_ack_out ? r_rdata : '0;
    bus.bus_err_out    = (r_state == ST_RESP) && r_err;
    bus.inst_stall_out = sys_rst && w_inst_req && !((r_state == ST_IDLE) && (w_gnt == GNT_INST));
    case (r_state)
      ST_IDLE: if (w_inst_req || w_data_req)
                 w_next = ((w_gnt == GNT_DATA) && w_mis) ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (w_abort)                                    w_next = ST_IDLE;
        else if (!bus.mem_stall_in && bus.mem_ack_in)   w_next = ST_RESP;
        else if (w_tmo)                                 w_next = ST_RESP;
        else if (!bus.mem_stall_in)                     w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_abort)              w_next = ST_IDLE;
        else if (bus.mem_ack_in)  w_next = ST_RESP;
        else if (w_tmo)           w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter and response data capture.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_owner <= GNT_INST;
      r_last  <= GNT_INST;
      r_size  <= SZ_WORD;
      r_lo    <= '0;
      r_waddr <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_err <= 1'b0;
          if (w_inst_req || w_data_req) begin
            r_owner <= w_gnt;
            r_last  <= w_gnt;
            r_size  <= w_sz;
            r_lo    <= w_lo;
            r_sel   <= w_sel;
            r_waddr <= (w_gnt == GNT_DATA) ? bus.data_addr_in[31:2] : bus.inst_addr_in[31:2];
            r_we    <= (w_gnt == GNT_DATA) && bus.data_we_in;
            r_wdata <= (w_gnt == GNT_DATA) ? w_wdata : '0;
            if ((w_gnt == GNT_DATA) && w_mis) begin
              r_err   <= 1'b1;
              r_rdata <= ERR_DATA;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_take) r_rdata <= w_rdata;
          else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Randomized self-checking bench for cpu_bus_arb with a transaction-level model.
module tb_cpu_bus_arb;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;
  bit   lg_data = 1'b0;   // model of last grant: 1 = data

  cpu_bus_arb_if bus();

  cpu_bus_arb #(.TIMEOUT_CYC(8), .ERR_DATA(32'h0000_0000)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [138:0] w_outs;
  assign w_outs = {bus.inst_ack_out, bus.inst_data_out, bus.inst_stall_out, bus.data_ack_out,
                   bus.data_data_out, bus.mem_cyc_out, bus.mem_stb_out, bus.mem_we_out,
                   bus.mem_sel_out, bus.mem_addr_out, bus.mem_data_out, bus.bus_err_out};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model: access size expressed as a byte count ----
  function automatic int nbytes(input logic [1:0] be);
    return (be == 2'b00) ? 1 : (be == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_sel(input logic [1:0] be, input logic [1:0] off);
    logic [31:0] s = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= int'(off)) && (i < int'(off) + nbytes(be));
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] be, input logic [31:0] d);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(be)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] be, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [31:0] r = '0;
    for (int i = 0; i < nbytes(be); i++) r[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
    return r;
  endfunction

  function automatic bit m_mis(input logic [1:0] be, input logic [1:0] off);
    return (nbytes(be) == 2 && off[0]) || (nbytes(be) == 4 && off != 2'b00);
  endfunction

  task automatic set_inst(input bit on, input logic [31:0] a);
    bus.inst_cyc_in  = on;
    bus.inst_stb_in  = on;
    bus.inst_addr_in = a;
  endtask

  task automatic set_data(input bit on, input bit we, input logic [1:0] be,
                          input logic [31:0] a, input logic [31:0] d);
    bus.data_stb_in  = on;
    bus.data_we_in   = we;
    bus.data_be_in   = be;
    bus.data_addr_in = a;
    bus.data_data_in = d;
  endtask

  // Acts as the memory slave for one transaction and checks the owner's response.
  task automatic serve(input bit own_d, input bit mis, input logic [31:0] e_addr,
                       input logic [31:0] e_sel, input logic [31:0] e_wd, input bit e_we,
                       input int stalls, input int adly, input logic [31:0] rd,
                       input logic [31:0] e_rd, input bit i_wait, output int lat);
    int n = 0;
    do begin
      @(negedge sys_clk); n++;
      if (i_wait) chk("i_stall_hold", 32'(bus.inst_stall_out), 32'd1);
      if (mis)    chk("mis_nocyc", 32'(bus.mem_cyc_out), 32'd0);
    end while (!(bus.mem_stb_out || bus.data_ack_out || bus.inst_ack_out) && n < 20);
    if (!mis) begin
      chk("stb", 32'(bus.mem_stb_out), 32'd1);
      chk("addr", bus.mem_addr_out, e_addr);
      chk("sel", 32'(bus.mem_sel_out), e_sel);
      chk("we", 32'(bus.mem_we_out), 32'(e_we));
      if (e_we) chk("wdata", bus.mem_data_out, e_wd);
      for (int s = 0; s < stalls; s++) begin
        bus.mem_stall_in = 1'b1;
        @(negedge sys_clk); n++;
        chk("stall_stb", 32'(bus.mem_stb_out), 32'd1);
        chk("stall_addr", bus.mem_addr_out, e_addr);
      end
      bus.mem_stall_in = 1'b0;
      if (adly == 0) begin
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = rd;
        @(negedge sys_clk); n++;
      end else begin
        @(negedge sys_clk); n++;
        chk("wait_cyc_stb", 32'({bus.mem_cyc_out, bus.mem_stb_out}), 32'd2);
        for (int w = 1; w < adly; w++) begin
          @(negedge sys_clk); n++;
        end
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = rd;
        @(negedge sys_clk); n++;
      end
      bus.mem_ack_in  = 1'b0;
      bus.mem_data_in = $urandom;
    end
    lat = n;
    chk("ack_own", 32'(own_d ? bus.data_ack_out : bus.inst_ack_out), 32'd1);
    chk("ack_other", 32'(own_d ? bus.inst_ack_out : bus.data_ack_out), 32'd0);
    chk("rdata", own_d ? bus.data_data_out : bus.inst_data_out, e_rd);
    chk("err", 32'(bus.bus_err_out), 32'(mis));
    chk("resp_cyc", 32'(bus.mem_cyc_out), 32'd0);
    if (own_d) bus.data_stb_in = 1'b0;
    else begin
      bus.inst_cyc_in = 1'b0;
      bus.inst_stb_in = 1'b0;
    end
  endtask

  // Issues fetch and/or data requests together and serves them in model order.
  task automatic run(input bit wi, input bit wd, input logic [31:0] ia, input bit we,
                     input logic [1:0] be, input logic [31:0] da, input logic [31:0] dd,
                     input int stalls, input int adly, input logic [31:0] rd0, output int lat0);
    bit first_d, own_d, mis;
    int cnt, lat;
    logic [31:0] rd, e_rd, e_addr, e_wd, e_sel;
    set_inst(wi, ia);
    set_data(wd, we, be, da, dd);
    first_d = (wi && wd) ? !lg_data : wd;
    cnt     = (wi && wd) ? 2 : 1;
    lat0    = 0;
    #1;
    if (wi) chk("i_stall_req", 32'(bus.inst_stall_out), 32'(first_d));
    for (int k = 0; k < cnt; k++) begin
      own_d   = (k == 0) ? first_d : !first_d;
      lg_data = own_d;
      rd      = (k == 0) ? rd0 : $urandom;
      mis     = own_d && m_mis(be, da[1:0]);
      if (own_d) begin
        e_addr = {da[31:2], 2'b00};
        e_sel  = m_sel(be, da[1:0]);
        e_wd   = m_wdata(be, dd);
        e_rd   = mis ? 32'h0 : m_rdata(be, da[1:0], rd);
      end else begin
        e_addr = {ia[31:2], 2'b00};
        e_sel  = 32'hF;
        e_wd   = 32'h0;
        e_rd   = rd;
      end
      serve(own_d, mis, e_addr, e_sel, e_wd, own_d && we, stalls, adly, rd, e_rd,
            own_d && wi && (k == 0), lat);
      if (k == 0) lat0 = lat;
      @(negedge sys_clk);
      chk("ack_pulse", 32'({bus.inst_ack_out, bus.data_ack_out}), 32'd0);
      if (k == 0 && cnt == 2 && first_d) chk("i_stall_gnt", 32'(bus.inst_stall_out), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1);
  end

  initial begin
    int lat, cnt, n, be_i, nb;
    logic [31:0] da;
    bus.mem_ack_in = 1'b0; bus.mem_stall_in = 1'b0; bus.mem_data_in = '0;
    // Reset state with both requests asserted.
    set_inst(1'b1, 32'h40);
    set_data(1'b1, 1'b1, 2'b00, 32'h44, 32'h55);
    repeat (2) @(negedge sys_clk);
    chk("rst_outs", 32'(|w_outs), 32'd0);
    set_inst(1'b0, '0); set_data(1'b0, 1'b0, 2'b00, '0, '0);
    sys_rst = 1'b1; lg_data = 1'b0;
    @(negedge sys_clk);
    chk("idle_outs", 32'(|w_outs), 32'd0);

    // Fetch, ack the cycle after accept.
    run(1, 0, 32'h100, 0, 2'b10, '0, '0, 0, 1, 32'h0000_0013, lat);
    chk("lat_fetch", 32'(lat), 32'd3);
    // Byte write, then half read with 3 stall cycles.
    run(0, 1, '0, 1, 2'b00, 32'h203, 32'hAB, 0, 1, $urandom, lat);
    run(0, 1, '0, 0, 2'b01, 32'h302, '0, 3, 1, 32'hBEEF_1234, lat);
    // Contention straight after reset: data first, twice.
    sys_rst = 1'b0; @(negedge sys_clk); sys_rst = 1'b1; lg_data = 1'b0;
    @(negedge sys_clk);
    run(1, 1, 32'h104, 0, 2'b10, 32'h208, '0, 1, 0, $urandom, lat);
    run(1, 1, 32'h108, 1, 2'b01, 32'h20A, 32'h5A5A_C3C3, 0, 2, $urandom, lat);
    // Misaligned word read.
    run(0, 1, '0, 0, 2'b10, 32'h101, '0, 0, 0, $urandom, lat);

    // Fetch abort while waiting for ack; late ack ignored.
    set_inst(1'b1, 32'h600);
    @(negedge sys_clk); chk("ab_req", 32'(bus.mem_stb_out), 32'd1);
    @(negedge sys_clk); chk("ab_wait", 32'(bus.mem_cyc_out), 32'd1);
    set_inst(1'b0, 32'h600); lg_data = 1'b0;
    @(negedge sys_clk); chk("ab_drop", 32'(bus.mem_cyc_out), 32'd0);
    chk("ab_noack0", 32'(bus.inst_ack_out), 32'd0);
    bus.mem_ack_in = 1'b1;
    @(negedge sys_clk); bus.mem_ack_in = 1'b0;
    chk("ab_noack1", 32'({bus.inst_ack_out, bus.data_ack_out, bus.mem_cyc_out}), 32'd0);

    // Dead slave: timeout after 8 bus cycles.
    set_data(1'b1, 1'b0, 2'b10, 32'h700, '0); lg_data = 1'b1;
    cnt = 0; n = 0;
    do begin
      @(negedge sys_clk); n++;
      if (bus.mem_cyc_out) cnt++;
    end while (!(bus.data_ack_out || bus.inst_ack_out) && n < 40);
    chk("to_cyc", 32'(cnt), 32'd8);
    chk("to_ack", 32'(bus.data_ack_out), 32'd1);
    chk("to_data", bus.data_data_out, 32'h0);
    chk("to_err", 32'(bus.bus_err_out), 32'd1);
    bus.data_stb_in = 1'b0;
    @(negedge sys_clk);
    chk("to_err_pulse", 32'({bus.bus_err_out, bus.data_ack_out}), 32'd0);

    // Reset in the middle of WAIT.
    set_data(1'b1, 1'b0, 2'b10, 32'h400, '0);
    @(negedge sys_clk); chk("rw_req", 32'(bus.mem_stb_out), 32'd1);
    @(negedge sys_clk); chk("rw_wait", 32'({bus.mem_cyc_out, bus.mem_stb_out}), 32'd2);
    set_inst(1'b1, 32'h500);
    #2 sys_rst = 1'b0;
    #1 chk("rw_outs", 32'(|w_outs), 32'd0);
    set_inst(1'b0, '0); set_data(1'b0, 1'b0, 2'b00, '0, '0);
    @(negedge sys_clk); sys_rst = 1'b1; lg_data = 1'b0; bus.mem_ack_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); bus.mem_ack_in = 1'b0;
      chk("rw_noack", 32'({bus.inst_ack_out, bus.data_ack_out, bus.mem_cyc_out}), 32'd0);
    end

    // Randomized mix of single and contending requests.
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      be_i = $urandom_range(0, 3);
      nb   = nbytes(2'(be_i));
      da   = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        if (nb == 2) da[0] = 1'b0;
        if (nb == 4) da[1:0] = 2'b00;
      end
      run(mode != 1, mode != 0, $urandom, 1'($urandom_range(0, 1)), 2'(be_i), da, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 2), $urandom, lat);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
